hoop_field_mover: RTL and testbench
===================================

# hoop_field_mover

Multi-hoop successor to the single falling-hoop mover. Manages up to NUM_HOOPS independent power-up hoops that fall in 1/2^FRAC_BITS-pixel fixed point, each with its own park/fall state. Adds LFSR-randomised spawn columns, spawn cooldown, speed levels, per-hoop collect and tower-collision inputs, and miss/hit counters. Sits between the frame timing generator and the hoop draw/collision logic in the power-up path.

## Interface
- NUM_HOOPS, 4: number of hoop channels (1..8)
- FALL_SPEED, 100: base Y step per frame, fixed-point units
- SPEED_STEP, 32: extra Y step per speedLevel increment
- FRAC_BITS, 6: fractional bits of the Y position
- OBJECT_WIDTH_X, 28; OBJECT_HEIGHT_Y, 58: hoop size, pixels
- NUDGE_X, 30: extra X shift on tower collision, pixels
- SCREEN_W, 640; SCREEN_H, 480: playfield, pixels
- SPAWN_INTERVAL, 40: frames between spawns
- LFSR_SEED, 16'hACE1: nonzero LFSR reset value
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- startOfFrame  in  1  one-cycle pulse per video frame
- pause  in  1  freeze motion, cooldown and spawning
- spawnX  in  11  spawn column base, must be < SCREEN_W
- speedLevel  in  3  fall-speed level
- towerCollision  in  NUM_HOOPS  per-hoop tower hit, level, sampled every cycle
- collect  in  NUM_HOOPS  per-hoop player pickup, sampled every cycle
- topLeftX  out  NUM_HOOPS*11  packed X per hoop, hoop i at [11i+10:11i]
- topLeftY  out  NUM_HOOPS*11  packed signed Y per hoop
- active  out  NUM_HOOPS  hoop i is FALLING
- spawnPulse  out  1  one-cycle pulse when a hoop spawns
- missCount  out  8  hoops that left the screen bottom, saturating
- hitCount  out  8  hoops collected, saturating

## Operation
- Per hoop: Y_fp signed (11+FRAC_BITS) bits, X 11-bit unsigned integer; state PARKED or FALLING.
- PARK_Y = -4*OBJECT_HEIGHT_Y pixels; PARKED hoops hold Y_fp = PARK_Y<<FRAC_BITS, X unchanged.
- topLeftY = Y_fp >>> FRAC_BITS (arithmetic); outputs are registered state, no combinational path from inputs.
- LFSR: 16-bit Galois, mask 16'hB400, shifts every clk cycle regardless of pause.
- step = FALL_SPEED + speedLevel*SPEED_STEP, evaluated each frame.
- On startOfFrame with pause=0, for each FALLING hoop: if topLeftY > SCREEN_H -> PARKED, missCount+1; else Y_fp += step.
- Spawn on same startOfFrame, pause=0, cooldown==0, at least one PARKED hoop: lowest-index PARKED hoop -> FALLING, Y = -OBJECT_HEIGHT_Y pixels, X = spawnX + lfsr[8:0]; if X >= SCREEN_W-OBJECT_WIDTH_X subtract SCREEN_W-OBJECT_WIDTH_X once; cooldown <= SPAWN_INTERVAL-1; spawnPulse=1. A hoop parked in this frame cannot respawn in the same frame.
- Otherwise on startOfFrame with pause=0 and cooldown>0: cooldown-1. No PARKED hoop: cooldown stays 0, spawn deferred.
- towerCollision[i] with FALLING: X += OBJECT_WIDTH_X+NUDGE_X; if result >= SCREEN_W subtract SCREEN_W. Applies every asserted cycle, also during pause. Ignored when PARKED.
- collect[i] with FALLING: -> PARKED, hitCount+1, no miss. Ignored when PARKED.
- Priority per hoop per cycle: collect > bottom-exit park > move; tower nudge combines with move (X nudged, Y stepped same cycle). collect and towerCollision together: park, nudge dropped.
- Counters saturate at 255.

## Timing
- Reset (async assert, sync release): all PARKED, Y = PARK_Y, X = 0, active=0, spawnPulse=0, counters 0, cooldown 0, LFSR = LFSR_SEED.
- All updates take effect on the clk edge sampling the event; outputs change one cycle after the input cycle.
- spawnPulse high exactly the cycle after the spawning startOfFrame edge.
- Reset mid-frame aborts all motion; first spawn on first startOfFrame after release.

## Test plan
- Reset, pause=0, speedLevel=0, 1 frame -> hoop0 active, topLeftY0=-58, spawnPulse one cycle, X0 = spawnX+lfsr[8:0] (wrapped) matching LFSR model.
- Single hoop, 345 frames after spawn -> topLeftY0=481; frame 346 -> active0=0, missCount=1, topLeftY0=-232.
- X0=600 FALLING, towerCollision[0] one cycle -> X0=18; concurrent startOfFrame -> Y also steps 100.
- collect[1] and towerCollision[1] same cycle -> hoop1 parked, hitCount+1, X1 unchanged.
- NUM_HOOPS=4, 200 frames, no collects -> spawns at frames 1,41,81,121; fifth deferred until first park; no two hoops spawn in one frame.
- pause=1 for 50 frames mid-fall -> Y and cooldown frozen; towerCollision still nudges; on release motion resumes from frozen values.

Source files
------------

// File: rtl/hoop_field_mover.sv
`default_nettype none
// ==========================================================================
// hoop_field_mover : NUM_HOOPS fixed-point falling power-up hoops with
// LFSR spawn columns, cooldown, nudges and miss/hit counters.  Rev 1.0
// ==========================================================================
module hoop_field_mover #(
  parameter int NUM_HOOPS       = 4,
  parameter int FALL_SPEED      = 100,
  parameter int SPEED_STEP      = 32,
  parameter int FRAC_BITS       = 6,
  parameter int OBJECT_WIDTH_X  = 28,
  parameter int OBJECT_HEIGHT_Y = 58,
  parameter int NUDGE_X         = 30,
  parameter int SCREEN_W        = 640,
  parameter int SCREEN_H        = 480,
  parameter int SPAWN_INTERVAL  = 40,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   startOfFrame,
  input  logic                   pause,
  input  logic [10:0]            spawnX,
  input  logic [2:0]             speedLevel,
  input  logic [NUM_HOOPS-1:0]   towerCollision,
  input  logic [NUM_HOOPS-1:0]   collect,
  output logic [NUM_HOOPS*11-1:0] topLeftX,
  output logic [NUM_HOOPS*11-1:0] topLeftY,
  output logic [NUM_HOOPS-1:0]   active,
  output logic                   spawnPulse,
  output logic [7:0]             missCount,
  output logic [7:0]             hitCount
);

  localparam int YW  = 11 + FRAC_BITS;
  localparam int CDW = $clog2(SPAWN_INTERVAL + 1);
  localparam int X_WRAP = SCREEN_W - OBJECT_WIDTH_X;
  localparam int NUDGE  = OBJECT_WIDTH_X + NUDGE_X;
  localparam logic signed [YW-1:0] PARK_Y_FP  = YW'(-(4 * OBJECT_HEIGHT_Y) * (1 << FRAC_BITS));
  localparam logic signed [YW-1:0] SPAWN_Y_FP = YW'(-OBJECT_HEIGHT_Y * (1 << FRAC_BITS));
  localparam logic signed [10:0]   SCREEN_H_S = 11'(SCREEN_H);

  typedef enum logic {PARKED = 1'b0, FALLING = 1'b1} hoop_state_t;

  hoop_state_t            state_q [NUM_HOOPS];
  hoop_state_t            state_d [NUM_HOOPS];
  logic signed [YW-1:0]   y_q [NUM_HOOPS];
  logic signed [YW-1:0]   y_d [NUM_HOOPS];
  logic [10:0]            x_q [NUM_HOOPS];
  logic [10:0]            x_d [NUM_HOOPS];
  logic [15:0]            lfsr_q, lfsr_d;
  logic [CDW-1:0]         cd_q, cd_d;
  logic [7:0]             miss_q, miss_d, hit_q, hit_d;
  logic                   spawn_q, spawn_d;

  logic                   frame, found, do_spawn;
  logic [NUM_HOOPS-1:0]   first_parked;
  logic [YW-1:0]          step;
  logic [11:0]            spawn_x, nudged_x;
  logic [3:0]             miss_inc, hit_inc;
  logic [8:0]             miss_sum, hit_sum;

  always_comb begin
    lfsr_d   = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    frame    = startOfFrame & ~pause;
    step     = YW'(FALL_SPEED) + YW'(speedLevel) * YW'(SPEED_STEP);
    spawn_x  = 12'(spawnX) + 12'(lfsr_q[8:0]);
    if (spawn_x >= 12'(X_WRAP))
      spawn_x = spawn_x - 12'(X_WRAP);

    // Eligibility uses start-of-cycle state, so a hoop parked now waits a frame.
    first_parked = '0;
    found        = 1'b0;
    for (int i = 0; i < NUM_HOOPS; i++) begin
      if (!found && state_q[i] == PARKED) begin
        first_parked[i] = 1'b1;
        found           = 1'b1;
      end
    end
    do_spawn = frame && (cd_q == '0) && found;

    miss_inc = '0;
    hit_inc  = '0;
    nudged_x = '0;
    for (int i = 0; i < NUM_HOOPS; i++) begin
      state_d[i] = state_q[i];
      y_d[i]     = y_q[i];
      x_d[i]     = x_q[i];
      if (state_q[i] == FALLING) begin
        if (collect[i]) begin
          state_d[i] = PARKED;
          y_d[i]     = PARK_Y_FP;
          hit_inc    = hit_inc + 4'd1;
        end else begin
          if (towerCollision[i]) begin
            nudged_x = 12'(x_q[i]) + 12'(NUDGE);
            if (nudged_x >= 12'(SCREEN_W))
              nudged_x = nudged_x - 12'(SCREEN_W);
            x_d[i] = nudged_x[10:0];
          end
          if (frame) begin
            if ($signed(y_q[i][YW-1:FRAC_BITS]) > SCREEN_H_S) begin
              state_d[i] = PARKED;
              y_d[i]     = PARK_Y_FP;
              miss_inc   = miss_inc + 4'd1;
            end else begin
              y_d[i] = y_q[i] + $signed(step);
            end
          end
        end
      end else if (do_spawn && first_parked[i]) begin
        state_d[i] = FALLING;
        y_d[i]     = SPAWN_Y_FP;
        x_d[i]     = spawn_x[10:0];
      end
    end

    cd_d = cd_q;
    if (do_spawn)
      cd_d = CDW'(SPAWN_INTERVAL - 1);
    else if (frame && cd_q != '0)
      cd_d = cd_q - 1'b1;

    miss_sum = 9'(miss_q) + 9'(miss_inc);
    hit_sum  = 9'(hit_q) + 9'(hit_inc);
    miss_d   = (miss_sum > 9'd255) ? 8'hFF : miss_sum[7:0];
    hit_d    = (hit_sum > 9'd255) ? 8'hFF : hit_sum[7:0];
    spawn_d  = do_spawn;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_HOOPS; i++) begin
        state_q[i] <= PARKED;
        y_q[i]     <= PARK_Y_FP;
        x_q[i]     <= '0;
      end
      lfsr_q  <= LFSR_SEED;
      cd_q    <= '0;
      miss_q  <= '0;
      hit_q   <= '0;
      spawn_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_HOOPS; i++) begin
        state_q[i] <= state_d[i];
        y_q[i]     <= y_d[i];
        x_q[i]     <= x_d[i];
      end
      lfsr_q  <= lfsr_d;
      cd_q    <= cd_d;
      miss_q  <= miss_d;
      hit_q   <= hit_d;
      spawn_q <= spawn_d;
    end
  end

  for (genvar g = 0; g < NUM_HOOPS; g++) begin : g_out
    assign topLeftX[11*g +: 11] = x_q[g];
    assign topLeftY[11*g +: 11] = y_q[g][YW-1:FRAC_BITS];
    assign active[g]            = (state_q[g] == FALLING);
  end

  assign spawnPulse = spawn_q;
  assign missCount  = miss_q;
  assign hitCount   = hit_q;

endmodule
`default_nettype wire

// File: tb/tb_hoop_field_mover.sv
`default_nettype none
// ==========================================================================
// tb_hoop_field_mover : random stimulus against a pixel/frame level model.
// Rev 1.0
// ==========================================================================
`timescale 1ns/1ps
module tb_hoop_field_mover;
  localparam int N = 4;
  localparam int PARK_FP  = -232 * 64;
  localparam int SPAWN_FP = -58 * 64;

  logic clk = 1'b0;
  logic reset, startOfFrame, pause;
  logic [10:0] spawnX;
  logic [2:0]  speedLevel;
  logic [N-1:0] towerCollision, collect;
  logic [N*11-1:0] topLeftX, topLeftY;
  logic [N-1:0] active;
  logic spawnPulse;
  logic [7:0] missCount, hitCount;

  hoop_field_mover dut (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .pause(pause),
    .spawnX(spawnX), .speedLevel(speedLevel), .towerCollision(towerCollision),
    .collect(collect), .topLeftX(topLeftX), .topLeftY(topLeftY), .active(active),
    .spawnPulse(spawnPulse), .missCount(missCount), .hitCount(hitCount)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  int m_y [N];
  int m_x [N];
  bit m_fall [N];
  int m_cd, m_miss, m_hit, m_lfsr;
  bit m_sp;

  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_y[i] = PARK_FP; m_x[i] = 0; m_fall[i] = 0;
    end
    m_cd = 0; m_miss = 0; m_hit = 0; m_lfsr = 'hACE1; m_sp = 0;
  endtask

  task automatic model_step();
    bit frame;
    int step, idx, nm, nh, sx;
    frame = startOfFrame && !pause;
    step  = 100 + int'(speedLevel) * 32;
    idx = -1;
    for (int i = 0; i < N; i++)
      if (idx < 0 && !m_fall[i]) idx = i;
    nm = 0; nh = 0;
    for (int i = 0; i < N; i++) begin
      if (m_fall[i]) begin
        if (collect[i]) begin
          m_fall[i] = 0; m_y[i] = PARK_FP; nh++;
        end else begin
          if (towerCollision[i]) begin
            m_x[i] += 58;
            if (m_x[i] >= 640) m_x[i] -= 640;
          end
          if (frame) begin
            if ((m_y[i] >>> 6) > 480) begin
              m_fall[i] = 0; m_y[i] = PARK_FP; nm++;
            end else begin
              m_y[i] += step;
            end
          end
        end
      end
    end
    m_sp = 0;
    if (frame) begin
      if (m_cd == 0 && idx >= 0) begin
        sx = int'(spawnX) + (m_lfsr % 512);
        if (sx >= 612) sx -= 612;
        m_fall[idx] = 1; m_y[idx] = SPAWN_FP; m_x[idx] = sx;
        m_cd = 39; m_sp = 1;
      end else if (m_cd > 0) begin
        m_cd--;
      end
    end
    m_miss = (m_miss + nm > 255) ? 255 : m_miss + nm;
    m_hit  = (m_hit + nh > 255) ? 255 : m_hit + nh;
    m_lfsr = (m_lfsr & 1) ? ((m_lfsr >> 1) ^ 'hB400) : (m_lfsr >> 1);
  endtask

  task automatic compare_all();
    for (int i = 0; i < N; i++) begin
      check($sformatf("x%0d", i), 32'(topLeftX[11*i +: 11]), m_x[i]);
      check($sformatf("y%0d", i), 32'($signed(topLeftY[11*i +: 11])), m_y[i] >>> 6);
      check($sformatf("active%0d", i), 32'(active[i]), 32'(m_fall[i]));
    end
    check("spawnPulse", 32'(spawnPulse), 32'(m_sp));
    check("missCount", 32'(missCount), m_miss);
    check("hitCount", 32'(hitCount), m_hit);
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) model_reset();
    else model_step();
    #1;
    compare_all();
  endtask

  task automatic rand_bits(input int one_in, output logic [N-1:0] v);
    for (int i = 0; i < N; i++) v[i] = ($urandom_range(0, one_in - 1) == 0);
  endtask

  initial begin
    reset = 1'b1; startOfFrame = 1'b0; pause = 1'b0; spawnX = '0;
    speedLevel = '0; towerCollision = '0; collect = '0;
    model_reset();
    tick();
    tick();
    reset = 1'b0;

    // Mixed traffic: variable frame periods, pause windows, nudges, sparse collects.
    for (int f = 0; f < 3000; f++) begin
      int period;
      period = $urandom_range(2, 6);
      speedLevel = 3'($urandom_range(0, 7));
      if (pause) pause = ($urandom_range(0, 9) != 0);
      else       pause = ($urandom_range(0, 49) == 0);
      for (int c = 0; c < period; c++) begin
        startOfFrame = (c == 0);
        spawnX = 11'($urandom_range(0, 639));
        rand_bits(16, towerCollision);
        rand_bits(1024, collect);
        tick();
      end
    end

    // Asynchronous reset in the middle of motion.
    startOfFrame = 1'b0; towerCollision = '0; collect = '0; pause = 1'b0;
    reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    tick();
    reset = 1'b0;

    // Heavy collecting at the fastest frame rate to drive hitCount into saturation.
    for (int f = 0; f < 10600; f++) begin
      speedLevel = 3'($urandom_range(0, 7));
      for (int c = 0; c < 2; c++) begin
        startOfFrame = (c == 0);
        spawnX = 11'($urandom_range(0, 639));
        rand_bits(8, towerCollision);
        rand_bits(2, collect);
        tick();
      end
    end
    check("hit_saturated", 32'(hitCount), 255);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
